// File: rtl/shadow_dump_ctrl.sv
// shadow_dump_ctrl: controller for the shadow capture unit on the add-pipe fraction datapath.
// It arms capture, then freezes it a programmable number of cycles after a trigger. It then
// dumps the selected scan chains one at a time, packing each serial bitstream LSB-first into
// words on a single-entry valid/ready output.
//
// Ports:
//   sh_clk, sh_rst_n      clock, asynchronous active-low reset
//   arm, trig, abort      control pulses (arm in IDLE, trig in CAPT, abort anywhere)
//   post_cnt              cycles c_en stays high after trig
//   chain_mask            chains to dump, sampled on trig
//   c_en                  capture enable to the shadow unit
//   dump_en               one-hot dump enable for the chain being read; 0 pauses shifting
//   ch_out/_vld/_done     per-chain serial data, bit valid, last bit delivered
//   out_data/chain/nbits/last/valid, out_ready   packed word stream
//   busy, done            not idle; one-cycle end-of-sequence pulse
//   err_chain             sticky per-chain timeout flags, cleared on arm
module shadow_dump_ctrl #(
    parameter int unsigned CHAINS  = 6,
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned POST_W  = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                    sh_clk,
    input  logic                    sh_rst_n,
    input  logic                    arm,
    input  logic                    trig,
    input  logic [POST_W-1:0]       post_cnt,
    input  logic [CHAINS-1:0]       chain_mask,
    input  logic                    abort,
    output logic                    c_en,
    output logic [CHAINS-1:0]       dump_en,
    input  logic [CHAINS-1:0]       ch_out,
    input  logic [CHAINS-1:0]       ch_out_vld,
    input  logic [CHAINS-1:0]       ch_out_done,
    output logic [WORD_W-1:0]       out_data,
    output logic [2:0]              out_chain,
    output logic [$clog2(WORD_W):0] out_nbits,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done,
    output logic [CHAINS-1:0]       err_chain
);

    localparam int unsigned NbW   = $clog2(WORD_W) + 1;
    localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StCapt  = 3'd1;
    localparam logic [2:0] StPost  = 3'd2;
    localparam logic [2:0] StSel   = 3'd3;
    localparam logic [2:0] StDump  = 3'd4;
    localparam logic [2:0] StFlush = 3'd5;
    localparam logic [2:0] StFin   = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [POST_W-1:0] post_q, post_d;
    logic [CHAINS-1:0] mask_q, mask_d;   // masked chains not yet serviced
    logic [2:0]        cur_q, cur_d;
    logic [WORD_W-1:0] pack_q, pack_d;
    logic [NbW-1:0]    bitcnt_q, bitcnt_d;
    logic [IdleW-1:0]  idle_q, idle_d;
    logic [CHAINS-1:0] err_q, err_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic [2:0]        out_chain_q, out_chain_d;
    logic [NbW-1:0]    out_nbits_q, out_nbits_d;
    logic              out_last_q, out_last_d;
    logic              out_valid_q, out_valid_d;

    logic              out_free, stall, en_cur, take, fin_chain, word_full, timeout;
    logic              cur_vld;
    logic [WORD_W-1:0] pack_new;
    logic [2:0]        sel_idx;

    assign out_free  = !out_valid_q || out_ready;
    // Pause the chain only when the next bit would complete a word with nowhere to put it.
    assign stall     = (bitcnt_q == NbW'(WORD_W - 1)) && !out_free;
    assign en_cur    = (state_q == StDump) && !stall;
    assign cur_vld   = ch_out_vld[cur_q];
    assign take      = en_cur && cur_vld;
    assign fin_chain = en_cur && ch_out_done[cur_q];
    assign word_full = take && (bitcnt_q == NbW'(WORD_W - 1));
    assign timeout   = en_cur && !cur_vld && (idle_q == IdleW'(TIMEOUT - 1));
    assign pack_new  = pack_q | (WORD_W'(ch_out[cur_q]) << bitcnt_q);

    always_comb begin
        sel_idx = '0;
        for (int i = int'(CHAINS) - 1; i >= 0; i--) begin
            if (mask_q[i]) sel_idx = 3'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        post_d      = post_q;
        mask_d      = mask_q;
        cur_d       = cur_q;
        pack_d      = pack_q;
        bitcnt_d    = bitcnt_q;
        idle_d      = idle_q;
        err_d       = err_q;
        out_data_d  = out_data_q;
        out_chain_d = out_chain_q;
        out_nbits_d = out_nbits_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q && !out_ready;

        case (state_q)
            StIdle: begin
                if (arm) begin
                    state_d = StCapt;
                    err_d   = '0;
                end
            end
            StCapt: begin
                if (trig) begin
                    state_d = StPost;
                    post_d  = post_cnt;
                    mask_d  = chain_mask;
                end
            end
            StPost: begin
                if (post_q == '0) state_d = StSel;
                else              post_d  = post_q - POST_W'(1);
            end
            StSel: begin
                if (mask_q == '0) begin
                    state_d = StFin;
                end else begin
                    state_d  = StDump;
                    cur_d    = sel_idx;
                    idle_d   = '0;
                    bitcnt_d = '0;
                    pack_d   = '0;
                end
            end
            StDump: begin
                if (take) begin
                    idle_d = '0;
                    if (word_full) begin
                        out_data_d  = pack_new;
                        out_chain_d = cur_q;
                        out_nbits_d = NbW'(WORD_W);
                        out_last_d  = fin_chain;
                        out_valid_d = 1'b1;
                        pack_d      = '0;
                        bitcnt_d    = '0;
                    end else begin
                        pack_d   = pack_new;
                        bitcnt_d = bitcnt_q + NbW'(1);
                    end
                end else if (en_cur) begin
                    idle_d = idle_q + IdleW'(1);
                end

                if (fin_chain) begin
                    // A word completed with the final bit already carries out_last.
                    if (word_full) begin
                        mask_d[cur_q] = 1'b0;
                        state_d       = StSel;
                    end else begin
                        state_d = StFlush;
                    end
                end else if (timeout) begin
                    err_d[cur_q] = 1'b1;
                    state_d      = StFlush;
                end
            end
            StFlush: begin
                if (out_free) begin
                    out_data_d    = pack_q;
                    out_chain_d   = cur_q;
                    out_nbits_d   = bitcnt_q;
                    out_last_d    = 1'b1;
                    out_valid_d   = 1'b1;
                    pack_d        = '0;
                    bitcnt_d      = '0;
                    mask_d[cur_q] = 1'b0;
                    state_d       = StSel;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            pack_d      = '0;
            bitcnt_d    = '0;
        end
    end

    always_ff @(posedge sh_clk or negedge sh_rst_n) begin
        if (!sh_rst_n) begin
            state_q     <= StIdle;
            post_q      <= '0;
            mask_q      <= '0;
            cur_q       <= '0;
            pack_q      <= '0;
            bitcnt_q    <= '0;
            idle_q      <= '0;
            err_q       <= '0;
            out_data_q  <= '0;
            out_chain_q <= '0;
            out_nbits_q <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            post_q      <= post_d;
            mask_q      <= mask_d;
            cur_q       <= cur_d;
            pack_q      <= pack_d;
            bitcnt_q    <= bitcnt_d;
            idle_q      <= idle_d;
            err_q       <= err_d;
            out_data_q  <= out_data_d;
            out_chain_q <= out_chain_d;
            out_nbits_q <= out_nbits_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    // c_en drops as soon as the post-trigger count is exhausted, so post_cnt=0 means no extra cycle.
    assign c_en      = (state_q == StCapt) || ((state_q == StPost) && (post_q != '0));
    assign dump_en   = en_cur ? (CHAINS'(1) << cur_q) : '0;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StFin);
    assign err_chain = err_q;
    assign out_data  = out_data_q;
    assign out_chain = out_chain_q;
    assign out_nbits = out_nbits_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_shadow_dump_ctrl.sv
// Bench for shadow_dump_ctrl: a behavioural shadow-chain model drives the serial inputs, and a
// scoreboard of expected packed words is filled when each dump sequence is launched.
module tb_shadow_dump_ctrl;

    localparam int unsigned CHAINS  = 6;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned POST_W  = 8;
    localparam int unsigned TIMEOUT = 1024;

    typedef struct {
        logic [WORD_W-1:0] data;
        logic [2:0]        chain;
        logic [5:0]        nbits;
        logic              last;
    } word_t;

    logic              sh_clk;
    logic              sh_rst_n, arm, trig, abort, out_ready;
    logic [POST_W-1:0] post_cnt;
    logic [CHAINS-1:0] chain_mask, dump_en, ch_out, ch_out_vld, ch_out_done, err_chain;
    logic              c_en, out_last, out_valid, busy, done;
    logic [WORD_W-1:0] out_data;
    logic [2:0]        out_chain;
    logic [5:0]        out_nbits;

    logic [255:0] bits   [CHAINS];
    int           len    [CHAINS];
    bit           silent [CHAINS];
    int           idx    [CHAINS];
    bit           stall_req;
    word_t        sb_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    shadow_dump_ctrl #(
        .CHAINS (CHAINS),
        .WORD_W (WORD_W),
        .POST_W (POST_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .sh_clk     (sh_clk),
        .sh_rst_n   (sh_rst_n),
        .arm        (arm),
        .trig       (trig),
        .post_cnt   (post_cnt),
        .chain_mask (chain_mask),
        .abort      (abort),
        .c_en       (c_en),
        .dump_en    (dump_en),
        .ch_out     (ch_out),
        .ch_out_vld (ch_out_vld),
        .ch_out_done(ch_out_done),
        .out_data   (out_data),
        .out_chain  (out_chain),
        .out_nbits  (out_nbits),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .err_chain  (err_chain)
    );

    initial begin
        sh_clk = 1'b0;
        forever #5 sh_clk = ~sh_clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Shadow unit model plus output monitor. Inputs change on the falling edge; everything is
    // sampled 1 time unit before the rising edge so it matches what the DUT registers.
    initial begin : drv
        logic [CHAINS-1:0] take_vec;
        bit                hold_prev;
        logic [WORD_W-1:0] prev_data;
        word_t             w;
        take_vec    = '0;
        hold_prev   = 1'b0;
        prev_data   = '0;
        ch_out      = '0;
        ch_out_vld  = '0;
        ch_out_done = '0;
        out_ready   = 1'b1;
        forever begin
            @(negedge sh_clk);
            for (int i = 0; i < CHAINS; i++) if (take_vec[i]) idx[i]++;
            for (int i = 0; i < CHAINS; i++) begin
                if (silent[i]) begin
                    ch_out_vld[i]  = 1'b0;
                    ch_out_done[i] = 1'b0;
                    ch_out[i]      = 1'b0;
                end else begin
                    ch_out_vld[i]  = (idx[i] < len[i]);
                    ch_out[i]      = (idx[i] < len[i]) ? bits[i][idx[i]] : 1'b0;
                    // Done is raised together with the final bit.
                    ch_out_done[i] = (idx[i] + 1 >= len[i]);
                end
            end
            out_ready = !stall_req;
            #4;
            take_vec = dump_en & ch_out_vld;
            if (dump_en != '0) check_eq("dump_en_onehot", 64'($onehot(dump_en)), 1);
            if (hold_prev && out_valid) check_eq("hold_data", out_data, prev_data);
            hold_prev = out_valid && !out_ready;
            prev_data = out_data;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_word", 1, 0);
                end else begin
                    w = sb_q.pop_front();
                    check_eq("word_data", out_data, w.data);
                    check_eq("word_chain", out_chain, w.chain);
                    check_eq("word_nbits", out_nbits, w.nbits);
                    check_eq("word_last", out_last, w.last);
                end
            end
        end
    end

    task automatic set_chain(input int ch, input int n, input bit sil);
        len[ch]    = n;
        silent[ch] = sil;
        idx[ch]    = 0;
        for (int k = 0; k < 256; k++) bits[ch][k] = 1'($urandom_range(0, 1));
    endtask

    task automatic push_expected(input logic [CHAINS-1:0] m);
        word_t w;
        for (int i = 0; i < CHAINS; i++) begin
            if (m[i]) begin
                if (silent[i] || len[i] == 0) begin
                    w.data  = '0;
                    w.chain = 3'(i);
                    w.nbits = '0;
                    w.last  = 1'b1;
                    sb_q.push_back(w);
                end else begin
                    for (int b = 0; b < len[i]; b += int'(WORD_W)) begin
                        int nb;
                        nb = (len[i] - b < int'(WORD_W)) ? len[i] - b : int'(WORD_W);
                        w.data = '0;
                        for (int k = 0; k < nb; k++) w.data[k] = bits[i][b + k];
                        w.chain = 3'(i);
                        w.nbits = 6'(nb);
                        w.last  = (b + int'(WORD_W) >= len[i]);
                        sb_q.push_back(w);
                    end
                end
            end
        end
    endtask

    // Arm, trigger, then follow c_en through the post-trigger window.
    task automatic start_seq(input logic [POST_W-1:0] p, input logic [CHAINS-1:0] m,
                             input string tag);
        @(posedge sh_clk); #1 arm = 1'b1;
        @(posedge sh_clk); #1 arm = 1'b0;
        check_eq({tag, "_busy_armed"}, busy, 1);
        check_eq({tag, "_c_en_capt"}, c_en, 1);
        check_eq({tag, "_err_cleared"}, err_chain, 0);
        chain_mask = m;
        post_cnt   = p;
        trig       = 1'b1;
        @(posedge sh_clk); #1 trig = 1'b0;
        chain_mask = ~m;
        for (int k = 1; k <= int'(p) + 1; k++) begin
            check_eq($sformatf("%s_c_en_cyc%0d", tag, k), c_en, (k <= int'(p)) ? 1 : 0);
            if (k <= int'(p)) begin
                @(posedge sh_clk); #1;
            end
        end
    endtask

    task automatic wait_done(input string tag, input bit bp);
        int cyc   = 0;
        int bp_at = -1;
        bit got   = 1'b0;
        while (cyc < 5000 && !got) begin
            @(posedge sh_clk); #1;
            cyc++;
            if (bp && bp_at < 0 && out_valid) begin
                stall_req = 1'b1;
                bp_at     = cyc;
            end
            if (bp_at >= 0 && stall_req && cyc == bp_at + 50) begin
                check_eq({tag, "_bp_dump_en_low"}, dump_en, 0);
                stall_req = 1'b0;
            end
            if (done) got = 1'b1;
        end
        stall_req = 1'b0;
        check_eq({tag, "_done_seen"}, got, 1);
        @(posedge sh_clk); #1;
        check_eq({tag, "_done_single"}, done, 0);
        repeat (3) @(posedge sh_clk);
        #1;
        check_eq({tag, "_sb_empty"}, sb_q.size(), 0);
        check_eq({tag, "_idle"}, busy, 0);
    endtask

    task automatic wait_bits(input int ch, input int n, input string tag);
        int cyc = 0;
        while (idx[ch] < n && cyc < 3000) begin
            @(posedge sh_clk); #1;
            cyc++;
        end
        check_eq({tag, "_bits_reached"}, (idx[ch] >= n) ? 1 : 0, 1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before 1000000");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        sh_rst_n   = 1'b0;
        arm        = 1'b0;
        trig       = 1'b0;
        abort      = 1'b0;
        post_cnt   = '0;
        chain_mask = '0;
        stall_req  = 1'b0;
        for (int i = 0; i < CHAINS; i++) set_chain(i, 0, 1'b0);

        repeat (3) @(posedge sh_clk);
        #1;
        check_eq("rst_c_en", c_en, 0);
        check_eq("rst_dump_en", dump_en, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_meta", {out_chain, out_nbits, out_last}, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err_chain, 0);
        sh_rst_n = 1'b1;

        // Basic: one 40-bit chain of 0xA5 pattern.
        set_chain(0, 40, 1'b0);
        bits[0] = {32{8'hA5}};
        push_expected(6'b000001);
        start_seq(8'd3, 6'b000001, "basic");
        wait_done("basic", 1'b0);

        // Multi-chain order.
        set_chain(0, 8, 1'b0);
        set_chain(2, 8, 1'b0);
        set_chain(5, 8, 1'b0);
        push_expected(6'b100101);
        start_seq(8'd1, 6'b100101, "multi");
        wait_done("multi", 1'b0);

        // Backpressure on a 96-bit chain.
        set_chain(0, 96, 1'b0);
        push_expected(6'b000001);
        start_seq(8'd2, 6'b000001, "bp");
        wait_done("bp", 1'b1);

        // Timeout on silent chain 1, then chain 2 continues.
        set_chain(1, 0, 1'b1);
        set_chain(2, 8, 1'b0);
        push_expected(6'b000110);
        start_seq(8'd0, 6'b000110, "tmo");
        wait_done("tmo", 1'b0);
        check_eq("tmo_err_chain", err_chain, 6'b000010);

        // Abort while idle keeps the error flags.
        @(posedge sh_clk); #1 abort = 1'b1;
        @(posedge sh_clk); #1 abort = 1'b0;
        check_eq("abort_idle_err_kept", err_chain, 6'b000010);

        // Abort mid-dump.
        set_chain(0, 40, 1'b0);
        push_expected(6'b000001);
        start_seq(8'd0, 6'b000001, "abort");
        wait_bits(0, 10, "abort");
        abort = 1'b1;
        @(posedge sh_clk); #1 abort = 1'b0;
        check_eq("abort_dump_en", dump_en, 0);
        check_eq("abort_out_valid", out_valid, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_c_en", c_en, 0);
        sb_q.delete();
        repeat (2) @(posedge sh_clk);
        set_chain(0, 40, 1'b0);
        push_expected(6'b000001);
        start_seq(8'd3, 6'b000001, "rearm1");
        wait_done("rearm1", 1'b0);

        // Asynchronous reset mid-dump, after a timeout has set an error flag.
        set_chain(1, 0, 1'b1);
        set_chain(2, 40, 1'b0);
        push_expected(6'b000110);
        start_seq(8'd0, 6'b000110, "rst");
        wait_bits(2, 10, "rst");
        check_eq("rst_err_before", err_chain, 6'b000010);
        #2 sh_rst_n = 1'b0;
        #1;
        check_eq("rstmid_dump_en", dump_en, 0);
        check_eq("rstmid_out_valid", out_valid, 0);
        check_eq("rstmid_busy", busy, 0);
        check_eq("rstmid_err", err_chain, 0);
        sb_q.delete();
        repeat (2) @(posedge sh_clk);
        #1 sh_rst_n = 1'b1;
        set_chain(0, 40, 1'b0);
        push_expected(6'b000001);
        start_seq(8'd3, 6'b000001, "rearm2");
        wait_done("rearm2", 1'b0);

        // Empty mask with post_cnt=0: SEL then FIN, no words.
        start_seq(8'd0, 6'b000000, "mask0");
        @(posedge sh_clk); #1;
        check_eq("mask0_done_sel", done, 0);
        @(posedge sh_clk); #1;
        check_eq("mask0_done_fin", done, 1);
        @(posedge sh_clk); #1;
        check_eq("mask0_idle", busy, 0);
        check_eq("mask0_sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
